// File: rtl/poly_root_deflate_check_pkg.sv
// Shared fixed-point definitions for the Newton-Raphson cubic root solver and its deflation stage.
package nrp_pkg;

  localparam int WIDTH   = 16;
  localparam int FRAC    = 8;
  localparam int EPSILON = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC1 = 3'd1,
    MAC2 = 3'd2,
    MAC3 = 3'd3,
    DONE = 3'd4
  } state_t;

  // Full-width product shifted down by FRAC; the caller decides how to fit it into WIDTH bits.
  function automatic logic signed [2*WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    return p >>> FRAC;
  endfunction

  // Magnitude in WIDTH+1 bits so the most negative word does not wrap.
  function automatic logic [WIDTH:0] abs_ext(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] e;
    e = {v[WIDTH-1], v};
    if (e[WIDTH]) begin
      abs_ext = -e;
    end else begin
      abs_ext = e;
    end
  endfunction

endpackage

// File: rtl/poly_root_deflate_check_fx_mac.sv
// Combinational y = c + fx(a*b). Define NRP_DEFLATE_SAT_EN to saturate instead of wrapping.
module nrp_fx_mac
  import nrp_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y
);

`ifdef NRP_DEFLATE_SAT_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   prod_w;
  logic [WIDTH:0]     sum;

  // Clamp the shifted product, then clamp the extended sum.
  always_comb begin
    prod = fx_mul($signed(a), $signed(b));
    if (prod[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){prod[2*WIDTH-1]}}) begin
      prod_w = prod[WIDTH-1:0];
    end else if (prod[2*WIDTH-1]) begin
      prod_w = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      prod_w = {1'b0, {(WIDTH-1){1'b1}}};
    end
    sum = {c[WIDTH-1], c} + {prod_w[WIDTH-1], prod_w};
    if (sum[WIDTH] == sum[WIDTH-1]) begin
      y = sum[WIDTH-1:0];
    end else if (sum[WIDTH]) begin
      y = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      y = {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic [WIDTH-1:0] prod_w;

  // Two's-complement wrap: dropping MSBs of the product and of the sum.
  always_comb begin
    prod_w = WIDTH'(fx_mul($signed(a), $signed(b)));
    y      = c + prod_w;
  end
`endif

endmodule

// File: rtl/poly_root_deflate_check.sv
// Horner / synthetic-division check of a cubic at a candidate root, yielding residual and deflated quadratic.
// Optional saturating arithmetic: NRP_DEFLATE_SAT_EN (handled inside nrp_fx_mac).
module poly_root_deflate_check
  import nrp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] root,
  input  logic [WIDTH-1:0] coeff0,
  input  logic [WIDTH-1:0] coeff1,
  input  logic [WIDTH-1:0] coeff2,
  input  logic [WIDTH-1:0] coeff3,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] residual,
  output logic             pass,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  localparam logic [WIDTH:0] EPS = (WIDTH+1)'(EPSILON);

  state_t           state, next_state;
  logic [WIDTH-1:0] rt, c0, c1, c2;
  logic [WIDTH-1:0] b2, b1, b0, rem;
  logic [WIDTH-1:0] mac_b, mac_c, mac_y;

  nrp_fx_mac u_mac (
    .a (rt),
    .b (mac_b),
    .c (mac_c),
    .y (mac_y)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and the shared MAC operand select.
  always_comb begin
    next_state = state;
    mac_b      = b2;
    mac_c      = c2;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = MAC1;
        end else begin
          next_state = IDLE;
        end
      end
      MAC1: begin
        next_state = MAC2;
        mac_b      = b2;
        mac_c      = c2;
      end
      MAC2: begin
        next_state = MAC3;
        mac_b      = b1;
        mac_c      = c1;
      end
      MAC3: begin
        next_state = DONE;
        mac_b      = b0;
        mac_c      = c0;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture, Horner accumulation and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready    <= 1'b1;
      valid    <= 1'b0;
      pass     <= 1'b0;
      residual <= {WIDTH{1'b0}};
      q0       <= {WIDTH{1'b0}};
      q1       <= {WIDTH{1'b0}};
      q2       <= {WIDTH{1'b0}};
      rt       <= {WIDTH{1'b0}};
      c0       <= {WIDTH{1'b0}};
      c1       <= {WIDTH{1'b0}};
      c2       <= {WIDTH{1'b0}};
      b2       <= {WIDTH{1'b0}};
      b1       <= {WIDTH{1'b0}};
      b0       <= {WIDTH{1'b0}};
      rem      <= {WIDTH{1'b0}};
    end else begin
      // ready is high exactly while the FSM sits in IDLE.
      ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            rt    <= root;
            c0    <= coeff0;
            c1    <= coeff1;
            c2    <= coeff2;
            b2    <= coeff3;
            valid <= 1'b0;
          end
        end
        MAC1: b1  <= mac_y;
        MAC2: b0  <= mac_y;
        MAC3: rem <= mac_y;
        DONE: begin
          q2       <= b2;
          q1       <= b1;
          q0       <= b0;
          residual <= rem;
          pass     <= (abs_ext($signed(rem)) <= EPS);
          valid    <= 1'b1;
        end
        default: begin
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_root_deflate_check.sv
// Directed self-checking bench for poly_root_deflate_check (WIDTH=16, FRAC=8, EPSILON=8).
module tb_poly_root_deflate_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] root, coeff0, coeff1, coeff2, coeff3;
  logic        ready, valid, pass;
  logic [15:0] residual, q0, q1, q2;

  int n_checks = 0;
  int n_fail   = 0;

  poly_root_deflate_check dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .root     (root),
    .coeff0   (coeff0),
    .coeff1   (coeff1),
    .coeff2   (coeff2),
    .coeff3   (coeff3),
    .ready    (ready),
    .valid    (valid),
    .residual (residual),
    .pass     (pass),
    .q0       (q0),
    .q1       (q1),
    .q2       (q2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the inputs to catch any re-sampling.
  task automatic launch(input logic [15:0] r, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] a2, input logic [15:0] a3);
    root   = r;
    coeff0 = a0;
    coeff1 = a1;
    coeff2 = a2;
    coeff3 = a3;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    root   = 16'hDEAD;
    coeff0 = 16'hBEEF;
    coeff1 = 16'hBEEF;
    coeff2 = 16'hBEEF;
    coeff3 = 16'hBEEF;
  endtask

  // Remaining four edges of an operation, checking that valid rises on the 4th.
  task automatic finish_op(input string tag);
    tick();
    tick();
    tick();
    chk({tag, "_valid_early"}, {15'd0, valid}, 16'd0);
    tick();
    chk({tag, "_valid"}, {15'd0, valid}, 16'd1);
    chk({tag, "_ready"}, {15'd0, ready}, 16'd1);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] res, input logic ps,
                         input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    chk({tag, "_residual"}, residual, res);
    chk({tag, "_pass"}, {15'd0, pass}, {15'd0, ps});
    chk({tag, "_q0"}, q0, e0);
    chk({tag, "_q1"}, q1, e1);
    chk({tag, "_q2"}, q2, e2);
  endtask

  task automatic run(input string tag, input logic [15:0] r, input logic [15:0] a0,
                     input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] a3,
                     input logic [15:0] res, input logic ps, input logic [15:0] e0,
                     input logic [15:0] e1, input logic [15:0] e2);
    launch(r, a0, a1, a2, a3);
    chk({tag, "_busy"}, {15'd0, ready}, 16'd0);
    finish_op(tag);
    chk_res(tag, res, ps, e0, e1, e2);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    root   = 16'd0;
    coeff0 = 16'd0;
    coeff1 = 16'd0;
    coeff2 = 16'd0;
    coeff3 = 16'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk_res("rst", 16'd0, 1'b0, 16'd0, 16'd0, 16'd0);

    // 1-3x+2x^2 at x=1
    run("t1", 16'd256, 16'd256, 16'hFD00, 16'd512, 16'd0, 16'd0, 1'b1, 16'hFF00, 16'd512, 16'd0);
    // triple root at x=1
    run("t2", 16'd256, 16'd256, 16'hFD00, 16'd768, 16'hFF00, 16'd0, 1'b1, 16'hFF00, 16'd512, 16'hFF00);
    // p=x at x=2
    run("t3", 16'd512, 16'd0, 16'd256, 16'd0, 16'd0, 16'd512, 1'b0, 16'd256, 16'd0, 16'd0);
`ifdef NRP_DEFLATE_SAT_EN
    run("t4", 16'h0400, 16'h7F00, 16'h4000, 16'd0, 16'd0, 16'h7FFF, 1'b0, 16'h4000, 16'd0, 16'd0);
`else
    run("t4", 16'h0400, 16'h7F00, 16'h4000, 16'd0, 16'd0, 16'h7F00, 1'b0, 16'h4000, 16'd0, 16'd0);
`endif
    run("zero", 16'd300, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 16'd0, 16'd0, 16'd0);
    // root=0 passes coefficients straight through; residual=a0 exercises the EPSILON edge
    run("r0_m8", 16'd0, 16'hFFF8, 16'hFFF9, 16'd100, 16'hFFFD, 16'hFFF8, 1'b1, 16'hFFF9, 16'd100, 16'hFFFD);
    run("r0_m9", 16'd0, 16'hFFF7, 16'd7, 16'd0, 16'd0, 16'hFFF7, 1'b0, 16'd7, 16'd0, 16'd0);
    run("r0_p8", 16'd0, 16'd8, 16'd0, 16'd0, 16'd0, 16'd8, 1'b1, 16'd0, 16'd0, 16'd0);
    run("r0_min", 16'd0, 16'h8000, 16'd0, 16'd0, 16'd0, 16'h8000, 1'b0, 16'd0, 16'd0, 16'd0);
    // x^3 at raw root -1: fx(-1*1) floors to -1
    run("floor", 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 1'b1, 16'd0, 16'hFFFF, 16'd1);

    // reset aborts an operation in flight
    launch(16'd256, 16'd256, 16'hFD00, 16'd512, 16'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", {15'd0, ready}, 16'd1);
    chk("abort_valid", {15'd0, valid}, 16'd0);
    chk_res("abort", 16'd0, 1'b0, 16'd0, 16'd0, 16'd0);
    run("post_abort", 16'd256, 16'd256, 16'hFD00, 16'd768, 16'hFF00, 16'd0, 1'b1, 16'hFF00, 16'd512, 16'hFF00);

    // start while busy is ignored
    launch(16'd256, 16'd256, 16'hFD00, 16'd512, 16'd0);
    tick();
    root   = 16'd512;
    coeff0 = 16'd0;
    coeff1 = 16'd256;
    coeff2 = 16'd0;
    coeff3 = 16'd0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    chk("ign_valid_early", {15'd0, valid}, 16'd0);
    tick();
    chk("ign_valid", {15'd0, valid}, 16'd1);
    chk_res("ign", 16'd0, 1'b1, 16'hFF00, 16'd512, 16'd0);
    chk("ign_ready", {15'd0, ready}, 16'd1);

    // back-to-back request in the first ready cycle after results
    run("b2b", 16'd512, 16'd0, 16'd256, 16'd0, 16'd0, 16'd512, 1'b0, 16'd256, 16'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
